edge_gen: RTL and testbench
===========================

EDGE_GEN -- requirements
Module: edge_gen

Interface
REQ-001 SHALL have parameter LEN_W, default 8, width of the phase-length inputs.
REQ-002 SHALL have parameter CNT_W, default 8, width of the period-count input.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port start  input  1  request to launch a pulse train, sampled with ready.
REQ-006 SHALL have port ready  output  1  high when a start is accepted this cycle.
REQ-007 SHALL have port high_len  input  LEN_W  high-phase length in cycles, sampled on accept.
REQ-008 SHALL have port low_len  input  LEN_W  low-phase length in cycles, sampled on accept.
REQ-009 SHALL have port num  input  CNT_W  number of high+low periods, sampled on accept.
REQ-010 SHALL have port stop  input  1  abort request while busy.
REQ-011 SHALL have port wave  output  1  generated level signal, registered.
REQ-012 SHALL have port rise  output  1  one-cycle marker, high in the first cycle wave is 1 after being 0.
REQ-013 SHALL have port down  output  1  one-cycle marker, high in the first cycle wave is 0 after being 1.
REQ-014 SHALL have port busy  output  1  high in HIGH and LOW states.
REQ-015 SHALL have port done  output  1  one-cycle pulse on train completion or abort.

Function
REQ-016 SHALL implement FSM states IDLE, HIGH, LOW; every output is registered.
REQ-017 SHALL assert ready only in IDLE; accept = start && ready at edge T.
REQ-018 On accept, SHALL latch high_len, low_len and num; a latched length of 0 is treated as 1.
REQ-019 On accept with num>0, SHALL enter HIGH: wave=1, rise=1 in cycle T+1.
REQ-020 SHALL hold wave=1 for exactly high_len cycles, then enter LOW with wave=0 and down=1 for exactly low_len cycles.
REQ-021 At the end of LOW, if periods remain, SHALL return to HIGH (rise=1); otherwise SHALL enter IDLE with done=1 and ready=1 in that cycle.
REQ-022 Period counter SHALL decrement once per completed LOW phase; no wrap-around past 0.
REQ-023 On accept with num=0 (macro absent), SHALL stay IDLE, leave wave=0 and pulse done in cycle T+1.
REQ-024 stop in HIGH or LOW SHALL force IDLE next cycle: wave=0, done=1, down=1 only if wave was 1.
REQ-025 stop in IDLE SHALL be ignored; start asserted while busy SHALL be ignored, not queued.
REQ-026 rise and down SHALL never be high in the same cycle; each is high for exactly one cycle per edge.
REQ-027 Period = high_len+low_len cycles; total train length = num*(high_len+low_len) cycles from T+1.

Reset
REQ-028 rst high at a clock edge SHALL force IDLE, wave=0, rise=0, down=0, busy=0, done=0, ready=1 next cycle.
REQ-029 Reset mid-train SHALL abort without a down or done pulse; latched values are cleared to 0.

Configuration
REQ-030 Macro EDGE_GEN_CONT_EN defined: num=0 on accept SHALL start an endless train, ending only by stop or rst.
REQ-031 Macro EDGE_GEN_CONT_EN undefined: num=0 SHALL behave per REQ-023; no endless mode exists.

Verification
REQ-032 high_len=2, low_len=3, num=2, start at T -> wave 1 at T+1..T+2, 0 at T+3..T+5, 1 at T+6..T+7, 0 at T+8..T+10; rise at T+1, T+6; down at T+3, T+8; done at T+11.
REQ-033 high_len=0, low_len=0, num=1 -> wave 1 at T+1, 0 at T+2, done at T+3.
REQ-034 high_len=4, low_len=4, num=3, stop in second HIGH -> wave=0, down=1, done=1 next cycle; ready=1.
REQ-035 rst asserted during LOW of a num=5 train -> all outputs 0, ready=1 next cycle, no done pulse; new start accepted immediately.
REQ-036 num=0 -> without macro, done at T+1 and wave stays 0; with EDGE_GEN_CONT_EN, train runs at least 1000 cycles until stop.
REQ-037 start held high across a num=1 train -> second train accepted in the done cycle; rise reappears one cycle later.

Source files
------------

// File: rtl/edge_gen.sv
// Programmable pulse-train generator: high/low phase lengths and period count.
// Define EDGE_GEN_CONT_EN to make num=0 start an endless train.
module edge_gen #(
  parameter int LEN_W = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             ready,
  input  logic [LEN_W-1:0] high_len,
  input  logic [LEN_W-1:0] low_len,
  input  logic [CNT_W-1:0] num,
  input  logic             stop,
  output logic             wave,
  output logic             rise,
  output logic             down,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } state_e;

  state_e           state_q, state_d;
  logic             wave_q, wave_d;
  logic             rise_q, rise_d;
  logic             down_q, down_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
  logic [LEN_W-1:0] hl_q, hl_d;
  logic [LEN_W-1:0] ll_q, ll_d;
  logic [LEN_W-1:0] ph_q, ph_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [LEN_W-1:0] hl_in, ll_in;
  logic             launch;
  logic             more;
`ifdef EDGE_GEN_CONT_EN
  logic             cont_q, cont_d;
`endif

  // zero-length phases still last one cycle
  assign hl_in = (high_len == '0) ? LEN_W'(1) : high_len;
  assign ll_in = (low_len == '0) ? LEN_W'(1) : low_len;

`ifdef EDGE_GEN_CONT_EN
  assign launch = 1'b1;
  assign more   = cont_q || (per_q > CNT_W'(1));
`else
  assign launch = (num != '0);
  assign more   = (per_q > CNT_W'(1));
`endif

  always_comb begin
    state_d = state_q;
    wave_d  = wave_q;
    rise_d  = 1'b0;
    down_d  = 1'b0;
    done_d  = 1'b0;
    hl_d    = hl_q;
    ll_d    = ll_q;
    ph_d    = ph_q;
    per_d   = per_q;
`ifdef EDGE_GEN_CONT_EN
    cont_d  = cont_q;
`endif
    unique case (state_q)
      IDLE: begin
        wave_d = 1'b0;
        if (start && ready_q) begin
          hl_d  = hl_in;
          ll_d  = ll_in;
          per_d = num;
`ifdef EDGE_GEN_CONT_EN
          cont_d = (num == '0);
`endif
          if (launch) begin
            state_d = HIGH;
            wave_d  = 1'b1;
            rise_d  = 1'b1;
            ph_d    = hl_in - LEN_W'(1);
          end else begin
            done_d = 1'b1;
          end
        end
      end
      HIGH: begin
        if (stop) begin
          state_d = IDLE;
          wave_d  = 1'b0;
          done_d  = 1'b1;
          down_d  = wave_q;
        end else if (ph_q == '0) begin
          state_d = LOW;
          wave_d  = 1'b0;
          down_d  = 1'b1;
          ph_d    = ll_q - LEN_W'(1);
        end else begin
          ph_d = ph_q - LEN_W'(1);
        end
      end
      LOW: begin
        if (stop) begin
          state_d = IDLE;
          wave_d  = 1'b0;
          done_d  = 1'b1;
          down_d  = wave_q;
        end else if (ph_q == '0) begin
          if (per_q != '0) per_d = per_q - CNT_W'(1);
          if (more) begin
            state_d = HIGH;
            wave_d  = 1'b1;
            rise_d  = 1'b1;
            ph_d    = hl_q - LEN_W'(1);
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          ph_d = ph_q - LEN_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        wave_d  = 1'b0;
      end
    endcase
    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wave_q  <= 1'b0;
      rise_q  <= 1'b0;
      down_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
      hl_q    <= '0;
      ll_q    <= '0;
      ph_q    <= '0;
      per_q   <= '0;
`ifdef EDGE_GEN_CONT_EN
      cont_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      wave_q  <= wave_d;
      rise_q  <= rise_d;
      down_q  <= down_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      hl_q    <= hl_d;
      ll_q    <= ll_d;
      ph_q    <= ph_d;
      per_q   <= per_d;
`ifdef EDGE_GEN_CONT_EN
      cont_q  <= cont_d;
`endif
    end
  end

  assign wave  = wave_q;
  assign rise  = rise_q;
  assign down  = down_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign ready = ready_q;

endmodule

// File: tb/tb_edge_gen.sv
// Directed bench for edge_gen; output vector is {ready,busy,done,down,rise,wave}.
// Expected vectors are hand-derived cycle by cycle from the accept edge T.
module tb_edge_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       ready;
  logic [7:0] high_len;
  logic [7:0] low_len;
  logic [7:0] num;
  logic       stop;
  logic       wave;
  logic       rise;
  logic       down;
  logic       busy;
  logic       done;

  int n_chk  = 0;
  int n_pass = 0;

  edge_gen #(.LEN_W(8), .CNT_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .ready    (ready),
    .high_len (high_len),
    .low_len  (low_len),
    .num      (num),
    .stop     (stop),
    .wave     (wave),
    .rise     (rise),
    .down     (down),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] obs();
    return {ready, busy, done, down, rise, wave};
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // check the current cycle, then advance one cycle
  task automatic cyc(input string tag, input logic [5:0] exp);
    check(tag, 32'(obs()), 32'(exp));
    tick();
  endtask

  // present a start for one edge; returns in cycle T+1
  task automatic launch(input logic [7:0] h,
                        input logic [7:0] l,
                        input logic [7:0] n);
    high_len = h;
    low_len  = l;
    num      = n;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    // scramble inputs: only the accept-time values may matter
    high_len = 8'd7;
    low_len  = 8'd9;
    num      = 8'd6;
  endtask

  initial begin
    int rises;
    rst = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    high_len = '0;
    low_len = '0;
    num = '0;
    tick();
    tick();
    check("reset", 32'(obs()), 32'(6'b100000));
    rst = 1'b0;
    tick();
    check("idle", 32'(obs()), 32'(6'b100000));

    // h=2 l=3 n=2
    launch(8'd2, 8'd3, 8'd2);
    cyc("a_t1", 6'b010011);
    cyc("a_t2", 6'b010001);
    cyc("a_t3", 6'b010100);
    cyc("a_t4", 6'b010000);
    cyc("a_t5", 6'b010000);
    cyc("a_t6", 6'b010011);
    cyc("a_t7", 6'b010001);
    cyc("a_t8", 6'b010100);
    cyc("a_t9", 6'b010000);
    cyc("a_t10", 6'b010000);
    cyc("a_t11", 6'b101000);
    cyc("a_t12", 6'b100000);

    // zero lengths act as one cycle
    launch(8'd0, 8'd0, 8'd1);
    cyc("z_t1", 6'b010011);
    cyc("z_t2", 6'b010100);
    cyc("z_t3", 6'b101000);
    cyc("z_t4", 6'b100000);

    // stop during the second HIGH
    launch(8'd4, 8'd4, 8'd3);
    for (int i = 1; i < 9; i++) tick();
    cyc("s_t9", 6'b010011);
    check("s_t10", 32'(obs()), 32'(6'b010001));
    stop = 1'b1;
    tick();
    stop = 1'b0;
    cyc("s_abort", 6'b101100);
    check("s_after", 32'(obs()), 32'(6'b100000));

    // stop during LOW: no down pulse
    launch(8'd1, 8'd3, 8'd2);
    cyc("sl_t1", 6'b010011);
    check("sl_t2", 32'(obs()), 32'(6'b010100));
    stop = 1'b1;
    tick();
    cyc("sl_abort", 6'b101000);
    // stop in IDLE is ignored
    cyc("sl_idle", 6'b100000);
    stop = 1'b0;

    // start while busy is neither honoured nor queued
    launch(8'd3, 8'd1, 8'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc("b_t2", 6'b010001);
    cyc("b_t3", 6'b010001);
    cyc("b_t4", 6'b010100);
    cyc("b_t5", 6'b101000);
    cyc("b_t6", 6'b100000);

    // reset during LOW of a num=5 train
    launch(8'd2, 8'd3, 8'd5);
    tick();
    tick();
    check("r_low", 32'(obs()), 32'(6'b010100));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("r_rst", 32'(obs()), 32'(6'b100000));
    launch(8'd1, 8'd1, 8'd1);
    cyc("r_t1", 6'b010011);
    cyc("r_t2", 6'b010100);
    cyc("r_t3", 6'b101000);

    // start held across a num=1 train
    high_len = 8'd1;
    low_len = 8'd1;
    num = 8'd1;
    start = 1'b1;
    tick();
    cyc("h_t1", 6'b010011);
    cyc("h_t2", 6'b010100);
    cyc("h_t3", 6'b101000);
    start = 1'b0;
    cyc("h_t4", 6'b010011);
    cyc("h_t5", 6'b010100);
    cyc("h_t6", 6'b101000);
    cyc("h_t7", 6'b100000);

    // num=0
`ifdef EDGE_GEN_CONT_EN
    launch(8'd1, 8'd1, 8'd0);
    rises = 0;
    for (int i = 0; i < 1000; i++) begin
      if (rise) rises++;
      tick();
    end
    check("c_rises", 32'(rises), 32'd500);
    check("c_busy", 32'(obs()), 32'(6'b010011));
    stop = 1'b1;
    tick();
    stop = 1'b0;
    cyc("c_abort", 6'b101100);
    cyc("c_idle", 6'b100000);
`else
    rises = 0;
    launch(8'd2, 8'd2, 8'd0);
    cyc("n0_t1", 6'b101000);
    cyc("n0_t2", 6'b100000);
    for (int i = 0; i < 4; i++) begin
      if (rise || wave) rises++;
      tick();
    end
    check("n0_quiet", 32'(rises), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
